// File: rtl/hazard_pkg.sv
// Shared sizing constants for the load-use hazard scoreboard.
package hazard_pkg;
    localparam int HZ_REG_ADDR_W  = 5;
    localparam int HZ_LOAD_LAT    = 1;
    localparam int HZ_CNT_W       = 3;
    localparam int HZ_STALL_CNT_W = 16;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until a pending load result is usable.
module sb_entry
    import hazard_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [HZ_CNT_W-1:0] i_load_val,
    output logic                o_busy
);
    logic [HZ_CNT_W-1:0] r_cnt;

    // A reload takes priority so a second load to the same register restarts the wait.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detection: per-register countdowns drive stall, bubble and flush controls.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = HZ_REG_ADDR_W,
    parameter int LOAD_LAT    = HZ_LOAD_LAT,
    parameter int STALL_CNT_W = HZ_STALL_CNT_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_id_valid,
    input  logic [REG_ADDR_W-1:0]  i_id_rs1,
    input  logic [REG_ADDR_W-1:0]  i_id_rs2,
    input  logic                   i_id_use_rs1,
    input  logic                   i_id_use_rs2,
    input  logic [REG_ADDR_W-1:0]  i_id_rd,
    input  logic                   i_id_mem_read,
    input  logic                   i_ex_branch_taken,
    output logic                   o_pc_write,
    output logic                   o_if_id_write,
    output logic                   o_control_sel,
    output logic                   o_if_id_flush,
    output logic [STALL_CNT_W-1:0] o_stall_count
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [NUM_REGS-1:0]    w_busy;
    logic                   w_rs1_haz;
    logic                   w_rs2_haz;
    logic                   w_stall;
    logic                   w_issue;
    logic                   w_load_issue;
    logic [STALL_CNT_W-1:0] r_stall_count;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // x0 is hard-wired, so it can never be waiting on a load.
    assign w_busy[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_entry
            sb_entry u_entry (
                .i_clk      (i_clk),
                .i_reset    (i_reset),
                .i_load     (w_load_issue && (i_id_rd == REG_ADDR_W'(g))),
                .i_load_val (HZ_CNT_W'(LOAD_LAT)),
                .o_busy     (w_busy[g])
            );
        end
    endgenerate

    assign w_rs1_haz    = i_id_use_rs1 && (i_id_rs1 != '0) && w_busy[i_id_rs1];
    assign w_rs2_haz    = i_id_use_rs2 && (i_id_rs2 != '0) && w_busy[i_id_rs2];
    assign w_stall      = i_id_valid && (w_rs1_haz || w_rs2_haz);
    assign w_issue      = i_id_valid && !w_stall && !i_ex_branch_taken;
    assign w_load_issue = w_issue && i_id_mem_read && (i_id_rd != '0);

    // A taken branch overrides the stall: the ID instruction is squashed rather than held.
    always_comb begin
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_control_sel = 1'b0;
        o_if_id_flush = 1'b0;
        if (i_ex_branch_taken) begin
            o_control_sel = 1'b1;
            o_if_id_flush = 1'b1;
        end else if (w_stall) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_control_sel = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (w_stall && !i_ex_branch_taken) begin
            r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign o_stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: three scoreboard configurations exercised one after another.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst;
    logic       v   [3];
    logic [4:0] rs1 [3];
    logic       u1  [3];
    logic [4:0] rs2 [3];
    logic       u2  [3];
    logic [4:0] rd  [3];
    logic       mr  [3];
    logic       br  [3];
    logic       pcw [3];
    logic       ifw [3];
    logic       csel[3];
    logic       fl  [3];
    logic [1:0]  sc0;
    logic [15:0] sc1;
    logic [15:0] sc2;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] NORM  = 4'b1100;
    localparam logic [3:0] STALL = 4'b0010;
    localparam logic [3:0] BR    = 4'b1111;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .STALL_CNT_W(2)) u_d0 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(v[0]), .i_id_rs1(rs1[0]), .i_id_rs2(rs2[0]),
        .i_id_use_rs1(u1[0]), .i_id_use_rs2(u2[0]), .i_id_rd(rd[0]), .i_id_mem_read(mr[0]),
        .i_ex_branch_taken(br[0]), .o_pc_write(pcw[0]), .o_if_id_write(ifw[0]),
        .o_control_sel(csel[0]), .o_if_id_flush(fl[0]), .o_stall_count(sc0));

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .STALL_CNT_W(16)) u_d1 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(v[1]), .i_id_rs1(rs1[1]), .i_id_rs2(rs2[1]),
        .i_id_use_rs1(u1[1]), .i_id_use_rs2(u2[1]), .i_id_rd(rd[1]), .i_id_mem_read(mr[1]),
        .i_ex_branch_taken(br[1]), .o_pc_write(pcw[1]), .o_if_id_write(ifw[1]),
        .o_control_sel(csel[1]), .o_if_id_flush(fl[1]), .o_stall_count(sc1));

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(2), .STALL_CNT_W(16)) u_d2 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(v[2]), .i_id_rs1(rs1[2]), .i_id_rs2(rs2[2]),
        .i_id_use_rs1(u1[2]), .i_id_use_rs2(u2[2]), .i_id_rd(rd[2]), .i_id_mem_read(mr[2]),
        .i_ex_branch_taken(br[2]), .o_pc_write(pcw[2]), .o_if_id_write(ifw[2]),
        .o_control_sel(csel[2]), .o_if_id_flush(fl[2]), .o_stall_count(sc2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage slot on the negedge, then check the controls mid-cycle.
    task automatic step(input int d, input string tag, input logic iv,
                        input logic [4:0] irs1, input logic iu1,
                        input logic [4:0] irs2, input logic iu2,
                        input logic [4:0] ird, input logic imr, input logic ibr,
                        input logic [3:0] exp);
        @(negedge clk);
        v[d] = iv; rs1[d] = irs1; u1[d] = iu1; rs2[d] = irs2; u2[d] = iu2;
        rd[d] = ird; mr[d] = imr; br[d] = ibr;
        #1;
        chk(tag, {12'd0, pcw[d], ifw[d], csel[d], fl[d]}, {12'd0, exp});
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        v[d] = 0; u1[d] = 0; u2[d] = 0; mr[d] = 0; br[d] = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            v[i] = 0; rs1[i] = 0; u1[i] = 0; rs2[i] = 0; u2[i] = 0;
            rd[i] = 0; mr[i] = 0; br[i] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ctl", {12'd0, pcw[0], ifw[0], csel[0], fl[0]}, {12'd0, NORM});
        chk("reset_sc0", {14'd0, sc0}, 16'd0);

        // LOAD_LAT=1: lw x5 ; add x6,x5,x7
        step(0, "l1_lw",    1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(0, "l1_stall", 1, 5, 1, 7, 1, 6, 0, 0, STALL);
        chk("l1_sc_pre", {14'd0, sc0}, 16'd0);
        step(0, "l1_issue", 1, 5, 1, 7, 1, 6, 0, 0, NORM);
        chk("l1_sc", {14'd0, sc0}, 16'd1);

        // x0 never pending; unused sources never stall
        step(0, "x0_lw",    1, 0, 0, 0, 0, 0, 1, 0, NORM);
        step(0, "x0_use",   1, 0, 1, 0, 1, 6, 0, 0, NORM);
        step(0, "nu_lw",    1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(0, "nu_dep",   1, 5, 0, 5, 0, 6, 0, 0, NORM);
        chk("nu_sc", {14'd0, sc0}, 16'd1);

        // rs2-side hazard
        step(0, "r2_lw",    1, 0, 0, 0, 0, 9, 1, 0, NORM);
        step(0, "r2_stall", 1, 1, 1, 9, 1, 6, 0, 0, STALL);
        step(0, "r2_issue", 1, 1, 1, 9, 1, 6, 0, 0, NORM);
        chk("r2_sc", {14'd0, sc0}, 16'd2);

        // stall coinciding with a taken branch
        step(0, "br_lw",    1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(0, "br_flush", 1, 5, 1, 0, 0, 6, 0, 1, BR);
        step(0, "br_after", 1, 5, 1, 0, 0, 6, 0, 0, NORM);
        chk("br_sc", {14'd0, sc0}, 16'd2);

        // stall counter saturates at 3 with a 2-bit width
        step(0, "sat_lw1",  1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(0, "sat_st1",  1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(0, "sat_is1",  1, 5, 1, 0, 0, 6, 0, 0, NORM);
        chk("sat_sc3", {14'd0, sc0}, 16'd3);
        step(0, "sat_lw2",  1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(0, "sat_st2",  1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(0, "sat_is2",  1, 5, 1, 0, 0, 6, 0, 0, NORM);
        chk("sat_hold", {14'd0, sc0}, 16'd3);
        idle(0);

        // LOAD_LAT=3: three stall cycles
        step(1, "l3_lw",    1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(1, "l3_st1",   1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(1, "l3_st2",   1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(1, "l3_st3",   1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(1, "l3_issue", 1, 5, 1, 0, 0, 6, 0, 0, NORM);
        chk("l3_sc", sc1, 16'd3);

        // a flush does not clear a pending load
        step(1, "fl_lw",    1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(1, "fl_br",    1, 5, 1, 0, 0, 6, 0, 1, BR);
        step(1, "fl_st1",   1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(1, "fl_st2",   1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(1, "fl_issue", 1, 5, 1, 0, 0, 6, 0, 0, NORM);
        chk("fl_sc", sc1, 16'd5);
        idle(1);

        // LOAD_LAT=2: back-to-back loads to x5 restart the countdown
        step(2, "rl_lw1",   1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(2, "rl_lw2",   1, 0, 0, 0, 0, 5, 1, 0, NORM);
        step(2, "rl_st1",   1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(2, "rl_st2",   1, 5, 1, 0, 0, 6, 0, 0, STALL);
        step(2, "rl_issue", 1, 5, 1, 0, 0, 6, 0, 0, NORM);
        chk("rl_sc", sc2, 16'd2);
        idle(2);

        // reset asserted during a stall releases it next cycle
        step(0, "rs_lw",    1, 0, 0, 0, 0, 5, 1, 0, NORM);
        @(negedge clk);
        rst = 1'b1;
        v[0] = 1; rs1[0] = 5; u1[0] = 1; rs2[0] = 0; u2[0] = 0; rd[0] = 6; mr[0] = 0; br[0] = 0;
        #1;
        chk("rs_stall", {12'd0, pcw[0], ifw[0], csel[0], fl[0]}, {12'd0, STALL});
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs_release", {12'd0, pcw[0], ifw[0], csel[0], fl[0]}, {12'd0, NORM});
        chk("rs_sc", {14'd0, sc0}, 16'd0);
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
